// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the SPI configuration master.
// Holds the FSM state encoding, the default word width and the divider sizing function.
package spi_cfg_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    TRAIL = 3'd4,
    GAP   = 3'd5
  } state_t;

  // $clog2(1) is 0, so the counter is kept at least one bit wide.
  function automatic int div_cnt_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Divider counter for the SPI half-period: counts 0..CLK_DIV-1 while enabled.
// It ticks on the last count and is cleared synchronously by the FSM.
module spi_clk_div
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = div_cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI master that writes one WIDTH-bit word MSB-first into a shift-register slave.
// It captures the word the slave shifts back on sdo; every output is registered.
//
// Handshake: start is sampled only while busy=0. The accepting cycle is the
// one where start=1 and busy=0, and data_in is captured on that cycle only.
// busy stays high from the next cycle through the single done cycle, so a
// held start re-launches on the cycle after done.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             sclk,
  output logic             sdi,
  output logic             cs_b,
  input  logic             sdo,
  output state_t           dbg_state
);

  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_cfg_master: CLK_DIV must be >= 1");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("spi_cfg_master: WIDTH must be >= 2");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_rdata;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_sdi;
  logic             r_cs_b;
  logic             w_tick;
  logic             w_accept;
  logic             w_div_en;

  assign w_accept = (r_state == IDLE) && !r_busy && start;
  assign w_div_en = (r_state != IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_en   (w_div_en),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rdata   <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdi     <= 1'b0;
      r_cs_b    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy still high here means this is the done cycle: drop it, ignore start.
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (w_accept) begin
            r_tx      <= data_in;
            r_rx      <= '0;
            r_bit_cnt <= '0;
            r_cs_b    <= 1'b0;
            r_sdi     <= data_in[WIDTH-1];
            r_busy    <= 1'b1;
            r_state   <= LEAD;
          end
        end
        LEAD, LO: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_rx    <= {r_rx[WIDTH-2:0], sdo};
            r_state <= HI;
          end
        end
        HI: begin
          if (w_tick) begin
            r_sclk    <= 1'b0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt != LAST_BIT) begin
              r_tx    <= {r_tx[WIDTH-2:0], 1'b0};
              r_sdi   <= r_tx[WIDTH-2];
              r_state <= LO;
            end else begin
              r_state <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (w_tick) begin
            r_cs_b  <= 1'b1;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_rdata <= r_rx;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign sclk      = r_sclk;
  assign sdi       = r_sdi;
  assign cs_b      = r_cs_b;
  assign dbg_state = r_state;

endmodule
